vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA timing generator; successor to the fixed 640x480 vga block plus the free-running clk toggle.
//  Derives a pixel-rate clock enable and VGA_CLK from clk by an integer divider.
//  Generates h/v counters, sync, blank, frame/line strobes, with a programmable sync delay to match pixel-pipeline latency.
//  Sits between the board clock and the pixel renderer / VGA DAC pins.
// PARAMETERS
//  CLK_DIV    2    clk cycles per pixel; legal range >=2
//  CNT_W      10   width of h_counter / v_counter; must hold H_TOTAL-1 and V_TOTAL-1
//  H_VISIBLE  640  active pixels per line
//  H_FRONT    16   horizontal front porch, in pixels
//  H_SYNC     96   horizontal sync width, in pixels
//  H_BACK     48   horizontal back porch, in pixels
//  V_VISIBLE  480  active lines per frame
//  V_FRONT    10   vertical front porch, in lines
//  V_SYNC     2    vertical sync width, in lines
//  V_BACK     33   vertical back porch, in lines
//  HS_POL     0    active level of VGA_HS
//  VS_POL     0    active level of VGA_VS
//  SYNC_DELAY 0    pixel ticks of delay applied to VGA_HS, VGA_VS and VGA_BLANK_N; range 0..7
// PORTS
//  clk          in   1      system clock
//  reset        in   1      asynchronous, active-high reset
//  enable       in   1      run when high; when low, timing is held at its idle state
//  pix_en       out  1      one-clk strobe, once per pixel period
//  VGA_CLK      out  1      pixel clock, ~50% duty, registered
//  h_counter    out  CNT_W  current column, 0..H_TOTAL-1
//  v_counter    out  CNT_W  current line, 0..V_TOTAL-1
//  visible      out  1      high when h_counter<H_VISIBLE and v_counter<V_VISIBLE; undelayed
//  VGA_HS       out  1      horizontal sync, delayed by SYNC_DELAY
//  VGA_VS       out  1      vertical sync, delayed by SYNC_DELAY
//  VGA_BLANK_N  out  1      registered copy of visible, delayed by SYNC_DELAY
//  VGA_SYNC_N   out  1      constant 0
//  line_start   out  1      one-clk pulse when h_counter becomes 0
//  frame_start  out  1      one-clk pulse when counters become (0,0)
// BEHAVIOUR
//  - Timing totals:
//    - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK.
//    - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK.
//  - Reset (async) and enable low (sync, every clk):
//    - div_cnt=0, pix_en=0, VGA_CLK=0.
//    - h_counter=H_TOTAL-1, v_counter=V_TOTAL-1.
//    - VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_BLANK_N=0.
//    - visible=0, line_start=0, frame_start=0.
//    - All delay-line stages are loaded with these inactive values.
//  - Divider:
//    - div_cnt counts 0..CLK_DIV-1 and wraps.
//    - pix_en is registered and high in the clk cycle where div_cnt==CLK_DIV-1.
//    - VGA_CLK is registered and high while div_cnt>=CLK_DIV/2 (integer division).
//  - Counter update, on each pix_en cycle:
//    - h increments.
//    - At H_TOTAL-1, h wraps to 0 and v increments.
//    - At V_TOTAL-1, v wraps to 0.
//    - The first pix_en after reset or after enable rises lands on (0,0).
//  - Registered sync terms, updated on pix_en from the new counter values, so they are aligned with the counters:
//    - hs_act: h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1].
//    - vs_act: v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1].
//    - VGA_HS = hs_act ? HS_POL : ~HS_POL; VGA_VS uses VS_POL the same way.
//  - Delay line:
//    - HS, VS and BLANK_N pass through a SYNC_DELAY-deep shift register that advances only on pix_en.
//    - SYNC_DELAY=0 means a direct path.
//  - Strobes:
//    - line_start and frame_start are high for exactly the one clk cycle following the pix_en that moved h (and v) to 0.
//    - A frame_start cycle is always also a line_start cycle.
//  - Outputs hold their values between pix_en strobes.
//  - enable falling mid-line returns the block to the idle state on the next clk edge; no partial line completes.
// TESTING
//  - Reset, defaults: hold reset -> h=799, v=524, HS=1, VS=1, BLANK_N=0, VGA_CLK=0, pix_en=0.
//  - Release reset: first pix_en at clk 2 -> h=0, v=0, frame_start and line_start each high for 1 clk.
//  - CLK_DIV=2 then CLK_DIV=4: pix_en period is 2 / 4 clk; VGA_CLK is high 1 / 2 clk per period.
//  - Line timing, defaults: VGA_HS low for exactly 96 pix ticks starting at h=656; BLANK_N high for h=0..639 on lines 0..479.
//  - Frame timing, defaults: 420000 pix ticks between frame_start pulses; VS low on lines 490-491 only.
//  - SYNC_DELAY=2: HS falls 2 pix ticks after h=656; BLANK_N falls at h=642; counters are unaffected.
//  - enable low at h=300, v=100 for 5 clk -> idle values; after re-enable, the first pix_en gives (0,0) plus frame_start.
//  - Async reset asserted mid-pixel -> outputs take reset values without waiting for a clk edge.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Bundle between the VGA timing generator and its consumers (renderer and DAC pins).
// The generator side is master: it takes the run enable and drives every timing output.
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
);
  logic             enable;
  logic             pix_en;
  logic             VGA_CLK;
  logic [CNT_W-1:0] h_counter;
  logic [CNT_W-1:0] v_counter;
  logic             visible;
  logic             VGA_HS;
  logic             VGA_VS;
  logic             VGA_BLANK_N;
  logic             VGA_SYNC_N;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  enable,
    output pix_en, VGA_CLK, h_counter, v_counter, visible,
           VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, line_start, frame_start
  );

  modport slave (
    output enable,
    input  pix_en, VGA_CLK, h_counter, v_counter, visible,
           VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: integer clock divider, h/v counters, polarity-programmable
// syncs with a pixel-tick delay line for pipeline matching, and line/frame start strobes.
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int CNT_W      = 10,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int SYNC_DELAY = 0
) (
  input logic              clk,
  input logic              reset,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam logic HS_IDLE = ~HS_POL;
  localparam logic VS_IDLE = ~VS_POL;

  logic [DIV_W-1:0] r_divCnt;
  logic [DIV_W-1:0] w_divNext;
  logic             r_pixEn;
  logic             r_vgaClk;

  logic [CNT_W-1:0] r_hCnt;
  logic [CNT_W-1:0] r_vCnt;
  logic [CNT_W-1:0] w_hNext;
  logic [CNT_W-1:0] w_vNext;
  logic             w_hWrap;
  logic             w_vWrap;

  logic             w_hsLevel;
  logic             w_vsLevel;
  logic             w_blankNext;

  logic [SYNC_DELAY:0] r_hsPipe;
  logic [SYNC_DELAY:0] r_vsPipe;
  logic [SYNC_DELAY:0] r_blankPipe;

  logic             r_lineStart;
  logic             r_frameStart;

  assign w_divNext = (r_divCnt == DIV_LAST) ? '0 : r_divCnt + 1'b1;

  // pix_en and VGA_CLK are registered from the next divider value so both line up with div_cnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_divCnt <= '0;
      r_pixEn  <= 1'b0;
      r_vgaClk <= 1'b0;
    end else if (!bus.enable) begin
      r_divCnt <= '0;
      r_pixEn  <= 1'b0;
      r_vgaClk <= 1'b0;
    end else begin
      r_divCnt <= w_divNext;
      r_pixEn  <= (w_divNext == DIV_LAST);
      r_vgaClk <= (w_divNext >= DIV_HALF);
    end
  end

  assign w_hWrap = (r_hCnt == H_LAST);
  assign w_vWrap = (r_vCnt == V_LAST);
  assign w_hNext = w_hWrap ? '0 : r_hCnt + 1'b1;
  assign w_vNext = w_hWrap ? (w_vWrap ? '0 : r_vCnt + 1'b1) : r_vCnt;

  assign w_hsLevel   = ((w_hNext >= HS_FIRST) && (w_hNext <= HS_LAST)) ? HS_POL : HS_IDLE;
  assign w_vsLevel   = ((w_vNext >= VS_FIRST) && (w_vNext <= VS_LAST)) ? VS_POL : VS_IDLE;
  assign w_blankNext = (w_hNext < H_VIS) && (w_vNext < V_VIS);

  // Idle counters sit on the last position so the first pixel tick lands on (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hCnt <= H_LAST;
      r_vCnt <= V_LAST;
    end else if (!bus.enable) begin
      r_hCnt <= H_LAST;
      r_vCnt <= V_LAST;
    end else if (r_pixEn) begin
      r_hCnt <= w_hNext;
      r_vCnt <= w_vNext;
    end
  end

  // Stage 0 is aligned with the counters; each further stage adds one pixel tick of delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsPipe    <= {(SYNC_DELAY + 1){HS_IDLE}};
      r_vsPipe    <= {(SYNC_DELAY + 1){VS_IDLE}};
      r_blankPipe <= '0;
    end else if (!bus.enable) begin
      r_hsPipe    <= {(SYNC_DELAY + 1){HS_IDLE}};
      r_vsPipe    <= {(SYNC_DELAY + 1){VS_IDLE}};
      r_blankPipe <= '0;
    end else if (r_pixEn) begin
      r_hsPipe[0]    <= w_hsLevel;
      r_vsPipe[0]    <= w_vsLevel;
      r_blankPipe[0] <= w_blankNext;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        r_hsPipe[i]    <= r_hsPipe[i-1];
        r_vsPipe[i]    <= r_vsPipe[i-1];
        r_blankPipe[i] <= r_blankPipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else if (!bus.enable) begin
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_lineStart  <= r_pixEn && (w_hNext == '0);
      r_frameStart <= r_pixEn && (w_hNext == '0) && (w_vNext == '0);
    end
  end

  assign bus.pix_en      = r_pixEn;
  assign bus.VGA_CLK     = r_vgaClk;
  assign bus.h_counter   = r_hCnt;
  assign bus.v_counter   = r_vCnt;
  assign bus.visible     = (r_hCnt < H_VIS) && (r_vCnt < V_VIS);
  assign bus.VGA_HS      = r_hsPipe[SYNC_DELAY];
  assign bus.VGA_VS      = r_vsPipe[SYNC_DELAY];
  assign bus.VGA_BLANK_N = r_blankPipe[SYNC_DELAY];
  assign bus.VGA_SYNC_N  = 1'b0;
  assign bus.line_start  = r_lineStart;
  assign bus.frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations share clk/reset/enable and are compared
// every cycle against a tick-count model that derives position from elapsed clk edges.
module tb_vga_timing_gen;

  logic clk;
  logic reset;
  logic enable;
  int   edgeCount;
  int   testCount;
  int   failCount;

  vga_timing_gen_if #(.CNT_W(10)) bus0 ();
  vga_timing_gen_if #(.CNT_W(10)) bus1 ();
  vga_timing_gen_if #(.CNT_W(5))  bus2 ();

  assign bus0.enable = enable;
  assign bus1.enable = enable;
  assign bus2.enable = enable;

  vga_timing_gen u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  vga_timing_gen #(.CLK_DIV(4), .SYNC_DELAY(2)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .CNT_W(5),
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .HS_POL(1'b1), .VS_POL(1'b1), .SYNC_DELAY(1)
  ) u2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  logic [31:0] obs0, obs1, obs2;
  assign obs0 = {3'b0, bus0.h_counter, bus0.v_counter, bus0.pix_en, bus0.VGA_CLK, bus0.visible,
                 bus0.VGA_HS, bus0.VGA_VS, bus0.VGA_BLANK_N, bus0.VGA_SYNC_N,
                 bus0.line_start, bus0.frame_start};
  assign obs1 = {3'b0, bus1.h_counter, bus1.v_counter, bus1.pix_en, bus1.VGA_CLK, bus1.visible,
                 bus1.VGA_HS, bus1.VGA_VS, bus1.VGA_BLANK_N, bus1.VGA_SYNC_N,
                 bus1.line_start, bus1.frame_start};
  assign obs2 = {3'b0, 5'b0, bus2.h_counter, 5'b0, bus2.v_counter, bus2.pix_en, bus2.VGA_CLK,
                 bus2.visible, bus2.VGA_HS, bus2.VGA_VS, bus2.VGA_BLANK_N, bus2.VGA_SYNC_N,
                 bus2.line_start, bus2.frame_start};

  // Default-timing idle values: h=799, v=524, syncs high, everything else low.
  localparam logic [31:0] RST_EXP = {3'b0, 10'd799, 10'd524, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // k = clk edges since the block left idle. Ticks completed = k/div; tick n shows position n-1.
  function automatic logic [31:0] model(input int k, input int div,
                                        input int hv, input int hf, input int hsw, input int hb,
                                        input int vv, input int vf, input int vsw, input int vb,
                                        input int dly, input bit hp, input bit vp);
    int ht, vt, d, n, pos, p2, h, v, h2, v2;
    bit pix, vclk, vis, hsO, vsO, blank, ls, fs;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    pix = 1'b0; vclk = 1'b0; h = ht - 1; v = vt - 1;
    hsO = !hp; vsO = !vp; blank = 1'b0; ls = 1'b0; fs = 1'b0;
    if (k > 0) begin
      d    = k % div;
      pix  = (d == div - 1);
      vclk = (d >= div / 2);
      n    = k / div;
      if (n > 0) begin
        pos = (n - 1) % (ht * vt);
        h   = pos % ht;
        v   = pos / ht;
        ls  = (d == 0) && (h == 0);
        fs  = ls && (v == 0);
        p2  = n - 1 - dly;
        if (p2 >= 0) begin
          pos   = p2 % (ht * vt);
          h2    = pos % ht;
          v2    = pos / ht;
          hsO   = (h2 >= hv + hf && h2 < hv + hf + hsw) ? hp : !hp;
          vsO   = (v2 >= vv + vf && v2 < vv + vf + vsw) ? vp : !vp;
          blank = (h2 < hv) && (v2 < vv);
        end
      end
    end
    vis = (h < hv) && (v < vv);
    return {3'b0, 10'(h), 10'(v), pix, vclk, vis, hsO, vsO, blank, 1'b0, ls, fs};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset || !enable) edgeCount <= 0;
    else                  edgeCount <= edgeCount + 1;
  end

  always @(negedge clk) begin
    checkOutput("u0", obs0, model(edgeCount, 2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 1'b0, 1'b0));
    checkOutput("u1", obs1, model(edgeCount, 4, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0));
    checkOutput("u2", obs2, model(edgeCount, 3, 16, 2, 3, 4, 10, 1, 2, 3, 1, 1'b1, 1'b1));
  end

  initial begin
    testCount = 0;
    failCount = 0;
    reset  = 1'b1;
    enable = 1'b0;
    applyStimulus(3);
    checkOutput("rstDefaults", obs0, RST_EXP);
    reset  = 1'b0;
    enable = 1'b1;
    applyStimulus(5000);

    for (int i = 0; i < 5; i++) begin
      applyStimulus($urandom_range(300, 2500));
      enable = 1'b0;
      applyStimulus($urandom_range(1, 6));
      checkOutput("enableIdle", obs0, RST_EXP);
      enable = 1'b1;
    end

    applyStimulus(777);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncRstU0", obs0, RST_EXP);
    checkOutput("asyncRstU2", obs2, model(0, 3, 16, 2, 3, 4, 10, 1, 2, 3, 1, 1'b1, 1'b1));
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1500);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
